// File: rtl/acc_job_ctrl.sv
// Job controller: accepts a job length, sums doubled samples, returns one result.
// Build option: define ACC_JOB_CTRL_SAT_EN to clamp the sum on overflow instead of wrapping.
module acc_job_ctrl #(
    parameter int ACC_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [4:0]       start_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_num,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic             ovf;
    logic             armed;
    logic [ACC_W:0]   sum;
    logic             start_hs;

    // One spare bit catches the carry of a single step.
    assign sum = {1'b0, acc} + {{(ACC_W-10){1'b0}}, in_num, 1'b0};
    assign start_hs = start_valid & start_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_hs) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= start_len;
                        state <= (start_len != 5'd0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (in_valid) begin
`ifdef ACC_JOB_CTRL_SAT_EN
                        acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                        acc <= sum[ACC_W-1:0];
`endif
                        ovf <= ovf | sum[ACC_W];
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // start_ready stays low until the first edge after reset release.
    assign start_ready = (state == IDLE) & armed;
    assign in_ready    = (state == RUN) & ~abort;
    assign res_valid   = (state == DONE);
    assign res_data    = res_valid ? acc : '0;
    assign res_ovf     = res_valid & ovf;
    assign busy        = (state != IDLE);

endmodule

// File: doc/acc_job_ctrl.md
ACC_JOB_CTRL -- requirements
Module: acc_job_ctrl

Interface
REQ-001 Parameter ACC_W, default 15: accumulator/result width in bits, legal range 12..24.
REQ-002 clk  in  1  sole clock, rising-edge active.
REQ-003 rst  in  1  reset, asynchronous assert, active-high.
REQ-004 start_valid  in  1  job request.
REQ-005 start_ready  out  1  job request accepted this cycle when high together with start_valid.
REQ-006 start_len  in  5  samples in job, 0..31, sampled at start handshake.
REQ-007 abort  in  1  cancel the running job.
REQ-008 in_valid  in  1  sample present.
REQ-009 in_ready  out  1  sample consumed when high together with in_valid.
REQ-010 in_num  in  10  unsigned sample.
REQ-011 res_valid  out  1  result present.
REQ-012 res_ready  in  1  result taken when high together with res_valid.
REQ-013 res_data  out  ACC_W  job sum.
REQ-014 res_ovf  out  1  sticky: job sum exceeded 2^ACC_W-1.
REQ-015 busy  out  1  high in RUN or DONE.

Function
REQ-016 FSM states: IDLE, RUN, DONE; all outputs registered or decoded from state only, no input-to-output combinational path except in_ready from abort.
REQ-017 IDLE: start_ready=1, in_ready=0, res_valid=0.
REQ-018 Start handshake: acc<=0, ovf<=0, cnt<=start_len; next state RUN if start_len!=0, DONE if start_len==0 (result 0, no samples consumed).
REQ-019 RUN: in_ready = ~abort; start_ready=0; res_valid=0.
REQ-020 Sample handshake: acc <= acc + (in_num<<1), addend 11 bits zero-extended; cnt <= cnt-1.
REQ-021 Handshake with cnt==1: next state DONE; sum of that sample visible in res_data on first DONE cycle.
REQ-022 No in_valid in RUN: state, acc, cnt hold; no timeout.
REQ-023 abort=1 in RUN: next state IDLE, sample on in_num that cycle not consumed, acc/ovf discarded, no result produced; abort ignored in IDLE and DONE.
REQ-024 DONE: res_valid=1, res_data=acc, res_ovf=ovf, both stable until handshake; in_ready=0, start_ready=0.
REQ-025 Result handshake: next state IDLE; start_ready high the following cycle (no same-cycle start back-to-back).
REQ-026 Overflow: ovf sets when true sum of any step exceeds 2^ACC_W-1; stays set until next start handshake.
REQ-027 Latency: start handshake to first in_ready = 1 cycle; last sample handshake to res_valid = 1 cycle.

Reset
REQ-028 rst=1 forces state IDLE, acc=0, cnt=0, ovf=0 immediately, regardless of clk.
REQ-029 Reset values of outputs: start_ready=1 only after rst deasserts (0 while rst=1), in_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0.
REQ-030 Reset mid-job discards job; no partial result is ever presented.

Configuration
REQ-031 Macro ACC_JOB_CTRL_SAT_EN defined: on overflow acc clamps to 2^ACC_W-1 and holds there for remaining samples; ovf sets.
REQ-032 Macro undefined: acc wraps modulo 2^ACC_W; ovf still sets per REQ-026.

Verification
REQ-033 len=3, samples 1,2,3, res_ready=1 -> res_data=12, res_ovf=0, res_valid 1 cycle after third sample.
REQ-034 len=0 -> no in_ready pulse, res_valid next cycle, res_data=0, res_ovf=0.
REQ-035 ACC_W=15, len=31, all samples 1023 -> with SAT_EN res_data=32767, ovf=1; without res_data=63426 mod 32768=30658, ovf=1.
REQ-036 len=4, two samples of 100, abort on third valid cycle -> in_ready=0 that cycle, IDLE next cycle, no res_valid; next job len=1 sample 5 -> res_data=10, ovf=0.
REQ-037 len=2 samples 7,8 with in_valid gaps and res_ready held 0 for 5 cycles -> res_data=30 stable all 5 cycles, start_ready=0 until cycle after res handshake.
REQ-038 rst pulse mid-RUN after one sample of 500 -> outputs at reset values asynchronously; next job len=1 sample 1 -> res_data=2.
